// File: rtl/alu_cmd_issuer.sv
// Issue stage for the 4-op sequential ALU: buffers commands in a circular FIFO
// and launches at most one per clock onto registered alu_* outputs.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int DW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_din0,
    input  logic [DW-1:0]          in_din1,
    input  logic [1:0]             in_sel,
    input  logic                   hold,
    output logic [DW-1:0]          alu_din0,
    output logic [DW-1:0]          alu_din1,
    output logic [1:0]             alu_sel,
    output logic                   issue,
    output logic                   res_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             op_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    // Idle slot drives AND of zeros so the ALU output reads 0 between commands
    localparam cmd_t NOP = '{a: '0, b: '0, sel: 2'b10};

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    state_t        state_q, state_d;
    cmd_t          alu_q;
    logic          issue_q, res_valid_q;
    logic [7:0]    op_count_q;
    logic          push, pop, full, empty;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign push  = in_valid && !full;
    assign pop   = (state_q == RUN) && !hold && !empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = RUN;
            RUN: begin
                if (hold)                                     state_d = STALL;
                else if (pop && level_q == LVL_ONE && !push)  state_d = IDLE;
            end
            STALL:   if (!hold) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{a: in_din0, b: in_din1, sel: in_sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            alu_q       <= NOP;
            issue_q     <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            res_valid_q <= issue_q;
            issue_q     <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                alu_q      <= mem_q[rd_ptr_q];
                op_count_q <= op_count_q + 8'd1;
            end else begin
                alu_q <= NOP;
            end
        end
    end

    assign in_ready  = !full;
    assign alu_din0  = alu_q.a;
    assign alu_din1  = alu_q.b;
    assign alu_sel   = alu_q.sel;
    assign issue     = issue_q;
    assign res_valid = res_valid_q;
    assign level     = level_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int DW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, hold;
    logic [DW-1:0] in_din0, in_din1, alu_din0, alu_din1;
    logic [1:0]    in_sel, alu_sel;
    logic          issue, res_valid;
    logic [2:0]    level;
    logic [7:0]    op_count;

    alu_cmd_issuer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_din0(in_din0), .in_din1(in_din1), .in_sel(in_sel), .hold(hold),
        .alu_din0(alu_din0), .alu_din1(alu_din1), .alu_sel(alu_sel),
        .issue(issue), .res_valid(res_valid), .level(level), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: commands as a queue; "primed" means the issuer may pop next cycle.
    typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] b; logic [1:0] s;} cmd_t;
    cmd_t       q[$];
    bit         primed, mdl_on = 0;
    logic       e_iss, e_rv;
    logic [DW-1:0] e_a, e_b;
    logic [1:0] e_s;
    logic [7:0] e_cnt;

    always @(posedge clk) begin
        int  n;
        bit  pu, po;
        cmd_t c;
        if (rst) begin
            q.delete();
            primed = 0; e_iss = 0; e_rv = 0; e_a = 0; e_b = 0; e_s = 2'b10; e_cnt = 0;
            mdl_on = 1;
        end else if (mdl_on) begin
            n  = q.size();
            pu = in_valid && (n < DEPTH);
            po = primed && !hold && (n > 0);
            e_rv = e_iss;
            if (po) begin
                c = q.pop_front();
                e_iss = 1; e_a = c.a; e_b = c.b; e_s = c.s; e_cnt = e_cnt + 8'd1;
            end else begin
                e_iss = 0; e_a = 0; e_b = 0; e_s = 2'b10;
            end
            if (pu) q.push_back('{a: in_din0, b: in_din1, s: in_sel});
            if (n == 0)      primed = pu;
            else if (primed) primed = !hold && !(po && n == 1 && !pu);
            else             primed = !hold;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("issue",     issue,     e_iss);
            chk("res_valid", res_valid, e_rv);
            chk("alu_din0",  alu_din0,  e_a);
            chk("alu_din1",  alu_din1,  e_b);
            chk("alu_sel",   alu_sel,   e_s);
            chk("level",     level,     q.size());
            chk("in_ready",  in_ready,  q.size() < DEPTH);
            chk("op_count",  op_count,  e_cnt);
        end
    end

    // One clock with given inputs; reports whether the command was accepted.
    task automatic cyc(input bit v, input int a, input int b, input int s, input bit h,
                       output bit acc);
        in_valid = v; in_din0 = DW'(a); in_din1 = DW'(b); in_sel = 2'(s); hold = h;
        acc = v && in_ready && !rst;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit h);
        bit acc;
        cyc(0, 0, 0, 0, h, acc);
    endtask

    task automatic do_reset();
        rst = 1; idle(0); idle(0); rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int n_acc, n_iss, sent;
        rst = 1; in_valid = 0; in_din0 = 0; in_din1 = 0; in_sel = 0; hold = 0;
        @(posedge clk); #1;

        // T1 reset
        do_reset();
        chk("t1_in_ready", in_ready, 1);
        chk("t1_level", level, 0);
        chk("t1_issue", issue, 0);
        chk("t1_res_valid", res_valid, 0);
        chk("t1_alu_sel", alu_sel, 2);

        // T2 single op, issue two cycles after presentation
        cyc(1, 5, 3, 0, 0, acc);
        chk("t2_acc", acc, 1);
        chk("t2_issue_early", issue, 0);
        idle(0);
        chk("t2_issue", issue, 1);
        chk("t2_a", alu_din0, 5);
        chk("t2_b", alu_din1, 3);
        chk("t2_sel", alu_sel, 0);
        idle(0);
        chk("t2_res_valid", res_valid, 1);
        chk("t2_issue_off", issue, 0);
        chk("t2_sel_nop", alu_sel, 2);

        // T3 fill under hold, then drain
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, i + 1, 6 - i, i % 4, 1, acc);
            n_acc += int'(acc);
        end
        chk("t3_accepted", n_acc, 4);
        chk("t3_level", level, 4);
        chk("t3_in_ready", in_ready, 0);
        n_iss = 0;
        for (int i = 0; i < 8; i++) begin
            idle(0);
            n_iss += int'(issue);
        end
        chk("t3_issues", n_iss, 4);
        chk("t3_op_count", op_count, 5);

        // T4 simultaneous push and pop at level 2
        do_reset();
        cyc(1, 1, 1, 0, 1, acc);
        cyc(1, 2, 2, 1, 1, acc);
        idle(0);
        chk("t4_level_pre", level, 2);
        cyc(1, 3, 3, 2, 0, acc);
        chk("t4_level", level, 2);
        chk("t4_first", alu_din0, 1);
        cyc(1, 4, 4, 3, 0, acc);
        chk("t4_level2", level, 2);
        chk("t4_second", alu_din0, 2);
        for (int i = 0; i < 5; i++) idle(0);

        // T5 300 back-to-back ops, counter wraps
        do_reset();
        sent = 0;
        for (int i = 0; i < 400 && sent < 300; i++) begin
            cyc(1, sent % 8, (sent / 8) % 8, sent % 4, 0, acc);
            sent += int'(acc);
        end
        chk("t5_sent", sent, 300);
        for (int i = 0; i < 8; i++) idle(0);
        chk("t5_op_count", op_count, 44);
        chk("t5_level", level, 0);

        // T6 reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, i, i, 0, 1, acc);
        idle(0);
        idle(0);
        chk("t6_level_pre", level, 3);
        chk("t6_issue_pre", issue, 1);
        rst = 1; idle(0); rst = 0;
        chk("t6_level", level, 0);
        chk("t6_issue", issue, 0);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_op_count", op_count, 0);
        idle(0);
        chk("t6_res_valid2", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
